// File: rtl/irq_pkg.sv
// Shared constants and types for the bus-mapped interrupt controller.
// Register offsets are relative to the block's BASE_ADDR.
package irq_pkg;

    localparam int MAX_SRC = 8;
    localparam int VEC_W   = 3;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_MODE  = 3'd2;
    localparam logic [2:0] REG_VEC   = 3'd3;
    localparam logic [2:0] REG_SWSET = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RAISED,
        GAP
    } state_t;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational priority search over enabled requests.
// Searches upward from ptr_i (or from 0 in fixed mode), wrapping modulo N_SRC.
module irq_prio_arb
    import irq_pkg::*;
#(
    parameter int N_SRC       = 3,
    parameter int ROUND_ROBIN = 0
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [VEC_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [VEC_W-1:0] idx_o
);

    logic [MAX_SRC-1:0] req8;
    logic [3:0]         base;
    logic [3:0]         j;

    assign req8 = MAX_SRC'(req_i);
    assign base = (ROUND_ROBIN != 0) ? {1'b0, ptr_i} : 4'd0;

    // Walk from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = base + 4'(k);
            if (j >= 4'(N_SRC)) begin
                j = j - 4'(N_SRC);
            end
            if (req8[j[2:0]]) begin
                valid_o = 1'b1;
                idx_o   = j[2:0];
            end
        end
    end

endmodule

// File: rtl/bus_irq_ctrl.sv
// Bus-mapped interrupt controller: pending/mask/mode registers, raise/ack
// handshake FSM toward the processor, and a registered tristate read port.
module bus_irq_ctrl
    import irq_pkg::*;
#(
    parameter int         N_SRC       = 3,
    parameter logic [7:0] BASE_ADDR   = 8'hE0,
    parameter int         ROUND_ROBIN = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [7:0]       BUS_DATA,
    input  logic [7:0]       BUS_ADDR,
    input  logic             BUS_WE,
    input  logic [N_SRC-1:0] IRQ_SRC,
    output logic [N_SRC-1:0] SRC_ACK,
    output logic             IRQ_RAISE,
    input  logic             IRQ_ACK
);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] ptr_q, ptr_d;
    logic [7:0]       rd_q, rd_d;
    logic             rd_en_q, rd_en_d;

    logic [7:0]       off;
    logic             hit;
    logic             fire;
    logic             arb_valid;
    logic [VEC_W-1:0] arb_idx;
    logic [N_SRC-1:0] pend, wdat, set, clr, ack_oh;

    assign off       = BUS_ADDR - BASE_ADDR;
    assign hit       = off < 8'd5;
    assign wdat      = BUS_DATA[N_SRC-1:0];
    // pend_q holds the edge flag in edge mode, the SWSET latch in level mode.
    assign pend      = pend_q | (~mode_q & src_q);
    assign IRQ_RAISE = state_q == RAISED;
    assign SRC_ACK   = ack_q;
    assign BUS_DATA  = rd_en_q ? rd_q : 8'hzz;

    irq_prio_arb #(
        .N_SRC      (N_SRC),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .req_i  (pend & mask_q),
        .ptr_i  (ptr_q),
        .valid_o(arb_valid),
        .idx_o  (arb_idx)
    );

    always_comb begin
        ack_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_oh[i] = vec_q == VEC_W'(i);
        end
    end

    always_comb begin
        set     = mode_q & IRQ_SRC & ~src_q;
        clr     = fire ? ack_oh : '0;
        mask_d  = mask_q;
        mode_d  = mode_q;
        rd_en_d = hit && !BUS_WE;
        rd_d    = '0;
        if (BUS_WE && hit) begin
            unique case (off[2:0])
                REG_PEND:  clr    = clr | wdat;
                REG_MASK:  mask_d = wdat;
                REG_MODE:  mode_d = wdat;
                REG_SWSET: set    = set | wdat;
                default:   ;
            endcase
        end
        pend_d = set | (pend_q & ~clr);
        unique case (off[2:0])
            REG_PEND: rd_d = 8'(pend);
            REG_MASK: rd_d = 8'(mask_q);
            REG_MODE: rd_d = 8'(mode_q);
            REG_VEC:  rd_d = {IRQ_RAISE, 4'b0, vec_q};
            default:  rd_d = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ptr_d   = ptr_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    vec_d   = arb_idx;
                    state_d = RAISED;
                end
            end
            RAISED: begin
                if (IRQ_ACK) begin
                    fire    = 1'b1;
                    state_d = GAP;
                    if (ROUND_ROBIN != 0) begin
                        ptr_d = (vec_q == VEC_W'(N_SRC - 1)) ? '0 : vec_q + 3'd1;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack_d = fire ? ack_oh : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '1;
            src_q   <= '0;
            ack_q   <= '0;
            vec_q   <= '0;
            ptr_q   <= '0;
            rd_q    <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            src_q   <= IRQ_SRC;
            ack_q   <= ack_d;
            vec_q   <= vec_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            rd_en_q <= rd_en_d;
        end
    end

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Self-checking bench: a fixed-priority and a round-robin instance share
// the same stimulus and are checked against a behavioural model.
module tb_bus_irq_ctrl;

    localparam int         N    = 3;
    localparam logic [7:0] BASE = 8'hE0;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   addr, wdata;
    logic         we, ack;
    logic [N-1:0] src;
    wire  [7:0]   bus0, bus1;
    logic [N-1:0] sack0, sack1;
    logic         raise0, raise1;

    int n_chk = 0;
    int n_err = 0;

    assign bus0 = we ? wdata : 8'hzz;
    assign bus1 = we ? wdata : 8'hzz;

    always #5 clk = ~clk;

    bus_irq_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .ROUND_ROBIN(0)) dut0 (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus0), .BUS_ADDR(addr),
        .BUS_WE(we), .IRQ_SRC(src), .SRC_ACK(sack0),
        .IRQ_RAISE(raise0), .IRQ_ACK(ack)
    );

    bus_irq_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .ROUND_ROBIN(1)) dut1 (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus1), .BUS_ADDR(addr),
        .BUS_WE(we), .IRQ_SRC(src), .SRC_ACK(sack1),
        .IRQ_RAISE(raise1), .IRQ_ACK(ack)
    );

    // Behavioural model, index 0 = fixed priority, 1 = round robin.
    bit [N-1:0] m_p[2], m_mask[2], m_mode[2], m_srcd[2], m_ack[2];
    int         m_stage[2], m_vec[2], m_ptr[2];
    bit         m_rdv[2];
    bit [7:0]   m_rd[2];

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset(int r);
        m_p[r] = '0; m_mask[r] = '0; m_mode[r] = '1; m_srcd[r] = '0;
        m_ack[r] = '0; m_stage[r] = 0; m_vec[r] = 0; m_ptr[r] = 0;
        m_rdv[r] = 0; m_rd[r] = '0;
    endfunction

    function automatic void model_step(int r);
        bit [N-1:0] eff, np;
        int off, win, j;
        bit acknow, set, clr;
        if (rst) begin
            model_reset(r);
            return;
        end
        off = int'(addr) - int'(BASE);
        for (int i = 0; i < N; i++)
            eff[i] = m_mode[r][i] ? m_p[r][i] : (m_srcd[r][i] | m_p[r][i]);
        m_rdv[r] = !we && off >= 0 && off <= 4;
        case (off)
            0: m_rd[r] = 8'(eff);
            1: m_rd[r] = 8'(m_mask[r]);
            2: m_rd[r] = 8'(m_mode[r]);
            3: m_rd[r] = {m_stage[r] == 1, 4'b0, 3'(m_vec[r])};
            default: m_rd[r] = '0;
        endcase
        win = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr[r] + k) % N;
            if (win < 0 && eff[j] && m_mask[r][j]) win = j;
        end
        acknow = m_stage[r] == 1 && ack;
        m_ack[r] = acknow ? N'(1 << m_vec[r]) : '0;
        for (int i = 0; i < N; i++) begin
            set = (m_mode[r][i] && src[i] && !m_srcd[r][i]) ||
                  (we && off == 4 && wdata[i]);
            clr = (we && off == 0 && wdata[i]) || (acknow && m_vec[r] == i);
            np[i] = set ? 1'b1 : clr ? 1'b0 : m_p[r][i];
        end
        m_p[r] = np;
        if (we && off == 1) m_mask[r] = wdata[N-1:0];
        if (we && off == 2) m_mode[r] = wdata[N-1:0];
        m_srcd[r] = src;
        if (acknow && r == 1) m_ptr[r] = (m_vec[r] + 1) % N;
        case (m_stage[r])
            0: if (win >= 0) begin m_vec[r] = win; m_stage[r] = 1; end
            1: if (ack) m_stage[r] = 2;
            default: m_stage[r] = 0;
        endcase
    endfunction

    task automatic cyc(input bit w, input bit [7:0] a, input bit [7:0] d,
                       input bit [N-1:0] s, input bit k);
        we = w; addr = a; wdata = d; src = s; ack = k;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("m0_raise", 8'(raise0), 8'(m_stage[0] == 1));
        chk("m1_raise", 8'(raise1), 8'(m_stage[1] == 1));
        chk("m0_srcack", 8'(sack0), 8'(m_ack[0]));
        chk("m1_srcack", 8'(sack1), 8'(m_ack[1]));
        if (m_rdv[0]) chk("m0_rdata", bus0, m_rd[0]);
        if (m_rdv[1]) chk("m1_rdata", bus1, m_rd[1]);
    endtask

    typedef struct {
        bit         w;
        bit [7:0]   a;
        bit [7:0]   d;
        bit [N-1:0] s;
        bit         k;
        bit         raise;
        bit [N-1:0] sack;
        bit         rdv;
        bit [7:0]   rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit prev_rd;
        bit [N-1:0] rs;
        bit rw;
        bit [7:0] ra;

        // {we, addr, data, src, ack, raise, srcack, read valid, read data}
        tbl.push_back('{0, 8'hE0, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h00});
        tbl.push_back('{0, 8'hE1, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h00});
        tbl.push_back('{0, 8'hE2, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h07});
        tbl.push_back('{0, 8'hE3, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{1, 8'hE1, 8'h07, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b010, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'hE3, 8'h00, 3'b000, 0, 1, 3'b000, 1, 8'h81});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 1, 0, 3'b010, 0, 8'h00});
        tbl.push_back('{0, 8'hE0, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b101, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'hE3, 8'h00, 3'b000, 0, 1, 3'b000, 1, 8'h80});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 1, 0, 3'b001, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'hE3, 8'h00, 3'b000, 0, 1, 3'b000, 1, 8'h82});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 1, 0, 3'b100, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{1, 8'hE0, 8'h02, 3'b010, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'hE0, 8'h00, 3'b000, 0, 1, 3'b000, 1, 8'h02});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 1, 0, 3'b010, 0, 8'h00});
        tbl.push_back('{0, 8'hE0, 8'h00, 3'b000, 0, 0, 3'b000, 1, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{1, 8'hE2, 8'h06, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 1, 0, 3'b001, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{1, 8'hE1, 8'h00, 3'b001, 0, 1, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 1, 0, 3'b001, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b001, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{0, 8'hE0, 8'h00, 3'b001, 0, 0, 3'b000, 1, 8'h01});
        tbl.push_back('{0, 8'h00, 8'h00, 3'b000, 0, 0, 3'b000, 0, 8'h00});
        tbl.push_back('{1, 8'hE2, 8'h07, 3'b000, 0, 0, 3'b000, 0, 8'h00});

        rst = 1'b1; we = 0; addr = 0; wdata = 0; src = 0; ack = 0;
        model_reset(0);
        model_reset(1);
        cyc(0, 8'h00, 8'h00, 3'b000, 0);
        cyc(0, 8'h00, 8'h00, 3'b000, 0);
        chk("reset_raise", 8'(raise0), 8'h00);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].k);
            chk($sformatf("row%0d_raise", i), 8'(raise0), 8'(tbl[i].raise));
            chk($sformatf("row%0d_srcack", i), 8'(sack0), 8'(tbl[i].sack));
            if (tbl[i].rdv)
                chk($sformatf("row%0d_rdata", i), bus0, tbl[i].rd);
        end

        // Reset while an interrupt is raised, with an ack offered at the same edge.
        cyc(1, 8'hE1, 8'h07, 3'b000, 0);
        cyc(1, 8'hE4, 8'h01, 3'b000, 0);
        cyc(0, 8'h00, 8'h00, 3'b000, 0);
        chk("pre_reset_raise", 8'(raise0), 8'h01);
        rst = 1'b1;
        cyc(0, 8'h00, 8'h00, 3'b000, 1);
        chk("rst_raise0", 8'(raise0), 8'h00);
        chk("rst_raise1", 8'(raise1), 8'h00);
        chk("rst_srcack", 8'(sack0), 8'h00);
        rst = 1'b0;
        cyc(0, 8'hE0, 8'h00, 3'b000, 0);
        chk("rst_pend", bus0, 8'h00);
        cyc(0, 8'hE1, 8'h00, 3'b000, 0);
        chk("rst_mask", bus0, 8'h00);
        cyc(0, 8'hE2, 8'h00, 3'b000, 0);
        chk("rst_mode", bus1, 8'h07);
        cyc(0, 8'hE3, 8'h00, 3'b000, 0);
        chk("rst_vec", bus1, 8'h00);
        cyc(0, 8'h00, 8'h00, 3'b000, 0);

        // Both sources kept pending: round robin alternates, fixed stays on 0.
        cyc(1, 8'hE1, 8'h03, 3'b000, 0);
        cyc(1, 8'hE4, 8'h03, 3'b000, 0);
        cyc(0, 8'h00, 8'h00, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 8'hE3, 8'h00, 3'b000, 0);
            chk($sformatf("rr_vec%0d", k), bus1, 8'h80 | 8'(k % 2));
            chk($sformatf("fix_vec%0d", k), bus0, 8'h80);
            cyc(0, 8'h00, 8'h00, 3'b000, 1);
            chk($sformatf("rr_ack%0d", k), 8'(sack1), 8'(1 << (k % 2)));
            cyc(1, 8'hE4, 8'h03, 3'b000, 0);
            cyc(0, 8'h00, 8'h00, 3'b000, 0);
        end

        // Randomised traffic against the model.
        prev_rd = 1'b1;
        rs = '0;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom % 200) == 0;
            rs = rs ^ N'($urandom & $urandom);
            rw = !prev_rd && ($urandom % 4) == 0;
            ra = ($urandom % 8 == 0) ? 8'($urandom) : BASE - 8'd1 + 8'($urandom % 7);
            cyc(rw, ra, 8'($urandom), rs, ($urandom % 3) == 0);
            prev_rd = !rw && ra >= BASE && ra <= BASE + 8'd4;
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_irq_ctrl.md
# bus_irq_ctrl

Parametrised, bus-mapped interrupt controller. It aggregates up to 8 peripheral interrupt sources (mouse, timer, switches and later additions) into the single raise/ack interrupt line pair of the Processor. It adds per-source masking, edge/level mode, software-set, selectable fixed or round-robin priority, and a readable vector register. It sits on the shared BUS_DATA/BUS_ADDR/BUS_WE data bus alongside RAM and the other peripherals.

## Interface
Parameters:
- N_SRC, 3: number of interrupt sources, legal range 1..8.
- BASE_ADDR, 8'hE0: bus address of register 0; the block decodes BASE_ADDR..BASE_ADDR+4.
- ROUND_ROBIN, 0: 0 = fixed priority (index 0 highest); 1 = rotating priority.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block, otherwise high-Z.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- IRQ_SRC  in  N_SRC  peripheral interrupt requests (SEND_INTERRUPT of each peripheral).
- SRC_ACK  out  N_SRC  one-cycle ack pulse back to the acknowledged source (its INTERRUPT_ACK).
- IRQ_RAISE  out  1  to one Processor BUS_INTERRUPTS_RAISE bit.
- IRQ_ACK  in  1  from the matching Processor BUS_INTERRUPTS_ACK bit.

## Operation
- Registers (offset: access). Bits above N_SRC read 0 and ignore writes.
  - 0 PEND: R, W1C.
  - 1 MASK: R/W, 1 = enabled.
  - 2 MODE: R/W, 1 = edge, 0 = level.
  - 3 VEC: R = {IRQ_RAISE, 4'b0, vec[2:0]}; writes are ignored.
  - 4 SWSET: W, writing 1 sets PEND; reads 0.
- Pending update, per source i, each cycle:
  - Edge mode: set on a 0->1 of IRQ_SRC[i] versus its 1-cycle-delayed copy, or on SWSET[i].
  - Edge mode: clear on W1C or on an ack of i.
  - Level mode: PEND[i] = registered IRQ_SRC[i] | a SWSET latch. W1C and ack clear only the SWSET latch.
  - Set beats clear when both happen in the same cycle.
- Arbitration over `PEND & MASK`:
  - Fixed mode: lowest index wins.
  - ROUND_ROBIN=1: search starts at ptr and wraps modulo N_SRC. After the ack of source k, ptr = (k+1) mod N_SRC.
- FSM:
  - IDLE: if any enabled pending, latch the winner into vec -> RAISED.
  - RAISED: IRQ_RAISE=1. vec is frozen (no preemption, no retraction if the source is later masked or cleared). On IRQ_ACK: apply the ack clear to vec, pulse SRC_ACK[vec], update ptr -> GAP.
  - GAP: IRQ_RAISE=0 for one cycle -> IDLE.
- Reset values:
  - PEND=0, MASK=0, MODE=all ones, ptr=0, vec=0, state IDLE.
  - IRQ_RAISE=0, SRC_ACK=0, BUS_DATA high-Z, delayed IRQ_SRC=0.

## Timing
- Write: takes effect at the edge where BUS_WE=1 and the address matches. The new value is readable from the next cycle.
- Read: address sampled with BUS_WE=0 at edge t. Read data and the drive enable are registered, so BUS_DATA is valid during cycle t+1 only, then high-Z.
- Interrupt latency: edge on IRQ_SRC at edge t -> PEND set at t+1 -> IRQ_RAISE high at t+2.
- Ack: IRQ_ACK sampled at edge a -> SRC_ACK pulse and IRQ_RAISE low during cycle a+1. Earliest re-raise is cycle a+3.
- IRQ_ACK outside RAISED is ignored.
- RESET mid-RAISED: IRQ_RAISE drops the next cycle; no SRC_ACK is issued.
- N_SRC=1: vec is always 0 and the rotation pointer is constant 0.

## Structure
- Package irq_pkg:
  - register offsets REG_PEND..REG_SWSET;
  - MAX_SRC=8;
  - state enum {IDLE, RAISED, GAP};
  - vector width 3.
- Sub-module irq_prio_arb: combinational request/pointer search producing a valid flag and a 3-bit index, parametrised by N_SRC and ROUND_ROBIN.
- The top level holds the registers, FSM, bus decode and tristate.

## Test plan
- Reset, then read offsets 0..3 -> 8'h00, 8'h00, 8'h07 (N_SRC=3), 8'h00; IRQ_RAISE=0.
- MASK=8'h07, pulse IRQ_SRC[1] -> IRQ_RAISE high 2 cycles later; VEC reads 8'h81. Assert IRQ_ACK -> SRC_ACK=3'b010 for one cycle, PEND reads 8'h00.
- Fixed mode, sources 2 and 0 rise in the same cycle -> first vec=0; after ack, 1 cycle low, then vec=2.
- ROUND_ROBIN=1, sources 0 and 1 held pending via SWSET repeatedly -> served order 0,1,0,1.
- Level mode on source 0 with IRQ_SRC[0] held high -> re-raises after every ack. MASK=0 -> no raise.
- W1C on bit 1 in the same cycle as a new edge on source 1 -> PEND[1] stays 1. RESET asserted during RAISED -> IRQ_RAISE=0 next cycle, all registers at reset values.
